hack_dma: RTL and testbench

- Bus-initiator block-copy engine for the HACK data memory bus; the initiator counterpart of data_mem.
- Drives the we / addr / data_in lines and samples data_out, exactly as the CPU does.
- Copies len words from src_addr to dst_addr, so RAM and MMIO regions (output regs 0x7000-0x7002, input regs 0x7400-0x7402) can be moved without CPU involvement.
- Sits beside the CPU; a top-level mux grants the bus while busy=1.

---
 rtl/hack_dma.sv | 157 +++++++++++++++
 tb/tb_hack_dma.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hack_dma.sv
// Block-copy bus initiator for the HACK data memory: copies len words from src_addr to dst_addr.
// Optional constant-fill mode is compiled in with `define HACK_DMA_FILL_EN.
module hack_dma #(
  parameter int AW     = 15,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk50m,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic          abort,
`ifdef HACK_DMA_FILL_EN
  input  logic          fill_mode,
  input  logic [DW-1:0] fill_val,
`endif
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW-1:0] words_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

  localparam logic [2:0]    CAP_LAST = 3'(RD_LAT - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);

  logic [2:0]    state_reg;
  logic [2:0]    cap_cnt_reg;
  logic [AW-1:0] src_reg;
  logic [AW-1:0] dst_reg;
  logic [AW-1:0] len_reg;
  logic [AW-1:0] idx_reg;
  logic [AW-1:0] words_done_reg;
  logic [DW-1:0] hold_reg;
  logic          aborted_reg;
`ifdef HACK_DMA_FILL_EN
  logic          fill_reg;
`endif

  // Next state after a committed write: back-to-back WR in fill mode, otherwise fetch the next word.
  logic [2:0] after_wr;
`ifdef HACK_DMA_FILL_EN
  assign after_wr = fill_reg ? WR : RD;
`else
  assign after_wr = RD;
`endif

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_reg      <= IDLE;
      cap_cnt_reg    <= '0;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      idx_reg        <= '0;
      words_done_reg <= '0;
      hold_reg       <= '0;
      aborted_reg    <= 1'b0;
`ifdef HACK_DMA_FILL_EN
      fill_reg       <= 1'b0;
`endif
    end else begin
      aborted_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // abort arriving together with start suppresses the request
          if (start && !abort) begin
            words_done_reg <= '0;
            if (len == '0) begin
              state_reg <= FIN;
            end else begin
              src_reg     <= src_addr;
              dst_reg     <= dst_addr;
              len_reg     <= len;
              idx_reg     <= '0;
              cap_cnt_reg <= '0;
`ifdef HACK_DMA_FILL_EN
              fill_reg    <= fill_mode;
              if (fill_mode) begin
                hold_reg  <= fill_val;
                state_reg <= WR;
              end else begin
                state_reg <= RD;
              end
`else
              state_reg   <= RD;
`endif
            end
          end
        end
        RD: begin
          if (abort) begin
            state_reg   <= IDLE;
            aborted_reg <= 1'b1;
          end else begin
            cap_cnt_reg <= '0;
            state_reg   <= CAP;
          end
        end
        CAP: begin
          if (abort) begin
            state_reg   <= IDLE;
            aborted_reg <= 1'b1;
          end else if (cap_cnt_reg == CAP_LAST) begin
            hold_reg  <= mem_rdata;
            state_reg <= WR;
          end else begin
            cap_cnt_reg <= cap_cnt_reg + 3'd1;
          end
        end
        WR: begin
          // The write on the bus this cycle always lands, even when aborted.
          words_done_reg <= words_done_reg + ONE;
          if (abort) begin
            state_reg   <= IDLE;
            aborted_reg <= 1'b1;
          end else if ((idx_reg + ONE) == len_reg) begin
            state_reg <= FIN;
          end else begin
            idx_reg   <= idx_reg + ONE;
            state_reg <= after_wr;
          end
        end
        FIN: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    case (state_reg)
      RD, CAP: mem_addr = src_reg + idx_reg;
      WR:      mem_addr = dst_reg + idx_reg;
      default: mem_addr = '0;
    endcase
  end

  assign busy       = (state_reg == RD) || (state_reg == CAP) || (state_reg == WR);
  assign done       = (state_reg == FIN);
  assign aborted    = aborted_reg;
  assign words_done = words_done_reg;
  assign mem_we     = (state_reg == WR);
  assign mem_wdata  = hold_reg;

endmodule

// File: tb/tb_hack_dma.sv
// Directed bench for hack_dma with a behavioural data_mem (read latency 1).
module tb_hack_dma;
  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk50m = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW-1:0] len = '0;
  logic          busy, done, aborted, mem_we;
  logic [AW-1:0] words_done, mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef HACK_DMA_FILL_EN
  logic          fill_mode = 1'b0;
  logic [DW-1:0] fill_val = '0;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  int            we_count = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  hack_dma #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .clk50m(clk50m), .rst(rst), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .abort(abort),
`ifdef HACK_DMA_FILL_EN
    .fill_mode(fill_mode), .fill_val(fill_val),
`endif
    .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #10 clk50m = ~clk50m;

  // data_mem model: registered read, write on we; bench preload through a side port
  always @(posedge clk50m) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_count <= we_count + 1;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk50m);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk50m);
    #1 poke_en = 1'b0;
  endtask

  // Runs one transfer; cyc = edges from raising start until done/aborted is seen.
  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l,
                     input int abort_wr, input int restart_at,
                     output int cyc, output logic dn, output logic ab);
    int wr_seen;
    wr_seen = 0; cyc = 0; dn = 1'b0; ab = 1'b0;
    @(negedge clk50m);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    while (!dn && !ab && cyc < 300) begin
      @(posedge clk50m);
      cyc++;
      @(negedge clk50m);
      start = 1'b0; abort = 1'b0;
      if (cyc == restart_at) begin
        start = 1'b1; len = 15'd1; src_addr = 15'h5555;
      end
      if (mem_we) begin
        wr_seen++;
        if (wr_seen == abort_wr) abort = 1'b1;
      end
      dn = done; ab = aborted;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_aborted"}, 32'(aborted), 32'd0);
    check({tag, "_words"}, 32'(words_done), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    int   cyc;
    logic dn, ab;
    int   we0;

    // reset state
    repeat (2) @(posedge clk50m);
    @(negedge clk50m);
    check_idle_outputs("reset");
    rst = 1'b0;

    poke(15'h0010, 16'h1111); poke(15'h0011, 16'h2222);
    poke(15'h0012, 16'h3333); poke(15'h0013, 16'h4444);
    poke(15'h0000, 16'hAFFE);
    poke(15'h7400, 16'hAFFE); poke(15'h7401, 16'hEDDA); poke(15'h7402, 16'hDADA);
    poke(15'h4003, 16'hDEAD);

    // 1: four-word copy
    we0 = we_count;
    run(15'h0010, 15'h3000, 15'd4, 0, 0, cyc, dn, ab);
    check("t1_done", 32'(dn), 32'd1);
    check("t1_cycles", 32'(cyc), 32'd13);
    check("t1_w0", 32'(mem[15'h3000]), 32'h1111);
    check("t1_w1", 32'(mem[15'h3001]), 32'h2222);
    check("t1_w2", 32'(mem[15'h3002]), 32'h3333);
    check("t1_w3", 32'(mem[15'h3003]), 32'h4444);
    check("t1_words", 32'(words_done), 32'd4);
    check("t1_we", 32'(we_count - we0), 32'd4);
    $display("t1 copy 0x0010->0x3000 len 4: cycles %0d", cyc);

    // 2: RAM to output register
    run(15'h0000, 15'h7002, 15'd1, 0, 0, cyc, dn, ab);
    check("t2_cycles", 32'(cyc), 32'd4);
    check("t2_out", 32'(mem[15'h7002]), 32'hAFFE);
    $display("t2 copy 0x0000->0x7002 len 1: cycles %0d", cyc);

    // 3: input registers to RAM
    run(15'h7400, 15'h0100, 15'd3, 0, 0, cyc, dn, ab);
    check("t3_cycles", 32'(cyc), 32'd10);
    check("t3_w0", 32'(mem[15'h0100]), 32'hAFFE);
    check("t3_w1", 32'(mem[15'h0101]), 32'hEDDA);
    check("t3_w2", 32'(mem[15'h0102]), 32'hDADA);
    $display("t3 copy 0x7400->0x0100 len 3: cycles %0d", cyc);

    // 4: source address wraps past 0x7FFF
    poke(15'h7FFE, 16'h0A01); poke(15'h7FFF, 16'h0A02); poke(15'h0000, 16'h0A03);
    run(15'h7FFE, 15'h1000, 15'd3, 0, 0, cyc, dn, ab);
    check("t4_done", 32'(dn), 32'd1);
    check("t4_w0", 32'(mem[15'h1000]), 32'h0A01);
    check("t4_w1", 32'(mem[15'h1001]), 32'h0A02);
    check("t4_w2", 32'(mem[15'h1002]), 32'h0A03);
    @(negedge clk50m);
    check("t4_busy_after", 32'(busy), 32'd0);
    $display("t4 wrap copy 0x7FFE->0x1000 len 3: cycles %0d", cyc);

    // 5a: abort during the third write
    we0 = we_count;
    run(15'h0010, 15'h4000, 15'd8, 3, 0, cyc, dn, ab);
    check("t5_aborted", 32'(ab), 32'd1);
    check("t5_done", 32'(dn), 32'd0);
    check("t5_cycles", 32'(cyc), 32'd10);
    check("t5_words", 32'(words_done), 32'd3);
    check("t5_w2", 32'(mem[15'h4002]), 32'h3333);
    repeat (5) @(negedge clk50m);
    check("t5_we", 32'(we_count - we0), 32'd3);
    check("t5_untouched", 32'(mem[15'h4003]), 32'hDEAD);
    check("t5_busy", 32'(busy), 32'd0);
    $display("t5 abort at 3rd write: cycles %0d words %0d", cyc, words_done);

    // 5b: zero-length request
    we0 = we_count;
    run(15'h0010, 15'h4000, 15'd0, 0, 0, cyc, dn, ab);
    check("t5z_cycles", 32'(cyc), 32'd1);
    check("t5z_done", 32'(dn), 32'd1);
    check("t5z_we", 32'(we_count - we0), 32'd0);
    check("t5z_words", 32'(words_done), 32'd0);
    $display("t5 len 0: cycles %0d", cyc);

    // 6a: reset in the middle of a transfer
    @(negedge clk50m);
    src_addr = 15'h0010; dst_addr = 15'h6000; len = 15'd8; start = 1'b1;
    @(negedge clk50m);
    start = 1'b0;
    repeat (5) @(negedge clk50m);
    check("t6_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk50m);
    check_idle_outputs("t6_rst");
    rst = 1'b0;
    $display("t6 reset mid-transfer");

    // 6b: a second start while busy is ignored
    run(15'h0010, 15'h5000, 15'd4, 0, 4, cyc, dn, ab);
    check("t6s_cycles", 32'(cyc), 32'd13);
    check("t6s_words", 32'(words_done), 32'd4);
    check("t6s_w0", 32'(mem[15'h5000]), 32'h1111);
    check("t6s_w3", 32'(mem[15'h5003]), 32'h4444);
    $display("t6 start during busy: cycles %0d", cyc);

`ifdef HACK_DMA_FILL_EN
    // 6c: constant fill
    we0 = we_count;
    fill_mode = 1'b1; fill_val = 16'hFFFF;
    run(15'h0000, 15'h0200, 15'd5, 0, 0, cyc, dn, ab);
    fill_mode = 1'b0;
    check("fill_cycles", 32'(cyc), 32'd6);
    check("fill_we", 32'(we_count - we0), 32'd5);
    check("fill_w0", 32'(mem[15'h0200]), 32'hFFFF);
    check("fill_w4", 32'(mem[15'h0204]), 32'hFFFF);
    $display("fill 0x0200 len 5: cycles %0d", cyc);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
